// File: rtl/pipelined_cpu.sv
// Five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB) with local memories,
// EX forwarding, one-cycle load-use stall and ID-resolved beq with IF/ID flush.

module PC (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [31:0] pc_i,
   output logic [31:0] pc_o
);
   logic [31:0] pc_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)     pc_q <= '0;
      else if (we_i) pc_q <= pc_i;
   assign pc_o = pc_q;
endmodule

module Instruction_Memory #(parameter int IMEM_WORDS = 256) (
   input  logic [$clog2(IMEM_WORDS)-1:0] addr_i,
   output logic [31:0]                   instr_o
);
   logic [31:0] memory [IMEM_WORDS];
   assign instr_o = memory[addr_i];
endmodule

module Data_Memory #(parameter int DMEM_BYTES = 32) (
   input  logic                            clk_i,
   input  logic                            we_i,
   input  logic [$clog2(DMEM_BYTES)-1:2]   wa_i,
   input  logic [31:0]                     wd_i,
   output logic [31:0]                     rd_o
);
   localparam int AW = $clog2(DMEM_BYTES);
   logic [7:0]    memory [DMEM_BYTES];
   logic [AW-1:0] a0, a1, a2, a3;
   assign a0 = {wa_i, 2'b00};
   assign a1 = {wa_i, 2'b01};
   assign a2 = {wa_i, 2'b10};
   assign a3 = {wa_i, 2'b11};
   assign rd_o = {memory[a3], memory[a2], memory[a1], memory[a0]};
   always_ff @(posedge clk_i)
      if (we_i) begin
         memory[a0] <= wd_i[7:0];
         memory[a1] <= wd_i[15:8];
         memory[a2] <= wd_i[23:16];
         memory[a3] <= wd_i[31:24];
      end
endmodule

module Registers (
   input  logic        clk_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic        we_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wd_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o
);
   logic [31:0] register [32];
   // Same-cycle WB write bypasses into the ID read
   assign rd1_o = (rs1_i == 5'd0) ? '0 : (we_i && rd_i == rs1_i) ? wd_i : register[rs1_i];
   assign rd2_o = (rs2_i == 5'd0) ? '0 : (we_i && rd_i == rs2_i) ? wd_i : register[rs2_i];
   always_ff @(posedge clk_i)
      if (we_i && rd_i != 5'd0) register[rd_i] <= wd_i;
endmodule

module Control (
   input  logic [6:0] op_i,
   input  logic [2:0] f3_i,
   input  logic [6:0] f7_i,
   output logic       Branch_o,
   output logic       RegWrite_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       ALUSrc_o,
   output logic [2:0] ALUOp_o
);
   // ALUOp: 0 add, 1 sub, 2 mul, 3 and, 4 or
   always_comb begin
      Branch_o = 1'b0; RegWrite_o = 1'b0; MemRead_o = 1'b0;
      MemWrite_o = 1'b0; ALUSrc_o = 1'b0; ALUOp_o = 3'd0;
      case (op_i)
         7'b0110011: begin
            if (f7_i == 7'b0000000 && f3_i == 3'b111)      begin RegWrite_o = 1'b1; ALUOp_o = 3'd3; end
            else if (f7_i == 7'b0000000 && f3_i == 3'b110) begin RegWrite_o = 1'b1; ALUOp_o = 3'd4; end
            else if (f7_i == 7'b0000000 && f3_i == 3'b000) begin RegWrite_o = 1'b1; ALUOp_o = 3'd0; end
            else if (f7_i == 7'b0100000 && f3_i == 3'b000) begin RegWrite_o = 1'b1; ALUOp_o = 3'd1; end
            else if (f7_i == 7'b0000001 && f3_i == 3'b000) begin RegWrite_o = 1'b1; ALUOp_o = 3'd2; end
         end
         7'b0010011: if (f3_i == 3'b000) begin RegWrite_o = 1'b1; ALUSrc_o = 1'b1; end
         7'b0000011: if (f3_i == 3'b010) begin RegWrite_o = 1'b1; MemRead_o = 1'b1; ALUSrc_o = 1'b1; end
         7'b0100011: if (f3_i == 3'b010) begin MemWrite_o = 1'b1; ALUSrc_o = 1'b1; end
         7'b1100011: if (f3_i == 3'b000) Branch_o = 1'b1;
         default: ;
      endcase
   end
endmodule

module HazardDetection (
   input  logic       idex_mem_read_i,
   input  logic [4:0] idex_rd_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic       branch_i,
   input  logic       equal_i,
   output logic       Stall_o,
   output logic       Flush_o
);
   assign Stall_o = idex_mem_read_i && idex_rd_i != 5'd0 && (idex_rd_i == rs1_i || idex_rd_i == rs2_i);
   assign Flush_o = branch_i && equal_i && !Stall_o;
endmodule

module pipelined_cpu #(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_BYTES = 32
) (
   input logic clk_i,
   input logic rst_i,
   input logic start_i
);
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_BYTES);

   typedef struct packed {
      logic reg_write, mem_read, mem_write, alu_src;
      logic [2:0] alu_op;
      logic [4:0] rs1, rs2, rd;
      logic [31:0] a, b, imm;
   } idex_t;
   typedef struct packed {
      logic reg_write, mem_read, mem_write;
      logic [4:0] rd;
      logic [31:0] alu, store;
   } exmem_t;
   typedef struct packed {
      logic reg_write, mem_read;
      logic [4:0] rd;
      logic [31:0] alu, load;
   } memwb_t;

   logic [31:0] pc, pc_next, instr_if, ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
   logic [31:0] rd1, rd2, imm_i, imm_s, imm_b, fwd_a, fwd_b, alu_b, alu_y, load_data, wb_data;
   logic [4:0]  rs1, rs2;
   logic [2:0]  alu_op;
   logic        pc_we, stall, flush, branch, reg_write, mem_read, mem_write, alu_src;
   idex_t       idex_q, idex_d;
   exmem_t      exmem_q, exmem_d;
   memwb_t      memwb_q, memwb_d;

   PC PC (.clk_i(clk_i), .rst_i(rst_i), .we_i(pc_we), .pc_i(pc_next), .pc_o(pc));
   Instruction_Memory #(.IMEM_WORDS(IMEM_WORDS)) Instruction_Memory (.addr_i(pc[IAW+1:2]), .instr_o(instr_if));

   assign rs1   = ifid_instr_q[19:15];
   assign rs2   = ifid_instr_q[24:20];
   assign imm_i = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
   assign imm_s = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
   assign imm_b = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                   ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};

   Control Control (.op_i(ifid_instr_q[6:0]), .f3_i(ifid_instr_q[14:12]), .f7_i(ifid_instr_q[31:25]),
                    .Branch_o(branch), .RegWrite_o(reg_write), .MemRead_o(mem_read),
                    .MemWrite_o(mem_write), .ALUSrc_o(alu_src), .ALUOp_o(alu_op));
   Registers Registers (.clk_i(clk_i), .rs1_i(rs1), .rs2_i(rs2), .we_i(memwb_q.reg_write),
                        .rd_i(memwb_q.rd), .wd_i(wb_data), .rd1_o(rd1), .rd2_o(rd2));
   HazardDetection HazardDetection (.idex_mem_read_i(idex_q.mem_read), .idex_rd_i(idex_q.rd),
                                    .rs1_i(rs1), .rs2_i(rs2), .branch_i(branch), .equal_i(rd1 == rd2),
                                    .Stall_o(stall), .Flush_o(flush));

   assign pc_we   = start_i && !stall;
   assign pc_next = flush ? ifid_pc_q + imm_b : pc + 32'd4;

   // With start_i low the PC parks, so IF/ID takes bubbles to let the pipe drain
   always_comb begin
      ifid_pc_d    = pc;
      ifid_instr_d = instr_if;
      if (stall) begin
         ifid_pc_d    = ifid_pc_q;
         ifid_instr_d = ifid_instr_q;
      end else if (flush || !start_i) begin
         ifid_instr_d = '0;
      end
   end

   always_comb begin
      idex_d = '0;
      if (!stall) begin
         idex_d.reg_write = reg_write;
         idex_d.mem_read  = mem_read;
         idex_d.mem_write = mem_write;
         idex_d.alu_src   = alu_src;
         idex_d.alu_op    = alu_op;
         idex_d.rs1       = rs1;
         idex_d.rs2       = rs2;
         idex_d.rd        = ifid_instr_q[11:7];
         idex_d.a         = rd1;
         idex_d.b         = rd2;
         idex_d.imm       = mem_write ? imm_s : imm_i;
      end
   end

   always_comb begin
      fwd_a = idex_q.a;
      if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)      fwd_a = exmem_q.alu;
      else if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) fwd_a = wb_data;
      fwd_b = idex_q.b;
      if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)      fwd_b = exmem_q.alu;
      else if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) fwd_b = wb_data;
      alu_b = idex_q.alu_src ? idex_q.imm : fwd_b;
      case (idex_q.alu_op)
         3'd1:    alu_y = fwd_a - alu_b;
         3'd2:    alu_y = fwd_a * alu_b;
         3'd3:    alu_y = fwd_a & alu_b;
         3'd4:    alu_y = fwd_a | alu_b;
         default: alu_y = fwd_a + alu_b;
      endcase
   end

   assign exmem_d = '{reg_write: idex_q.reg_write, mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
                      rd: idex_q.rd, alu: alu_y, store: fwd_b};

   Data_Memory #(.DMEM_BYTES(DMEM_BYTES)) Data_Memory (.clk_i(clk_i), .we_i(exmem_q.mem_write),
                     .wa_i(exmem_q.alu[DAW-1:2]), .wd_i(exmem_q.store), .rd_o(load_data));

   assign memwb_d = '{reg_write: exmem_q.reg_write, mem_read: exmem_q.mem_read, rd: exmem_q.rd,
                      alu: exmem_q.alu, load: load_data};
   assign wb_data = memwb_q.mem_read ? memwb_q.load : memwb_q.alu;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         ifid_pc_q    <= '0;
         ifid_instr_q <= '0;
         idex_q       <= '0;
         exmem_q      <= '0;
         memwb_q      <= '0;
      end else begin
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         idex_q       <= idex_d;
         exmem_q      <= exmem_d;
         memwb_q      <= memwb_d;
      end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed programs with hand-computed results for the pipelined_cpu core.
module tb_pipelined_cpu;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic start_i = 1'b1;
   int n_checks = 0;
   int n_pass = 0;
   int n_stall, n_flush, n_branch;
   logic [31:0] prog[$];
   logic [31:0] acc;

   pipelined_cpu #(.IMEM_WORDS(256), .DMEM_BYTES(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
      return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] dword(input int a);
      return {dut.Data_Memory.memory[a+3], dut.Data_Memory.memory[a+2],
              dut.Data_Memory.memory[a+1], dut.Data_Memory.memory[a]};
   endfunction

   // Reset asserted between edges; state is preloaded while the pipe is held in reset
   task automatic load_and_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) dut.Registers.register[i] = '0;
      for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = '0;
      foreach (prog[i]) dut.Instruction_Memory.memory[i] = prog[i];
      @(negedge clk_i);
      rst_i = 1'b0;
      n_stall = 0; n_flush = 0; n_branch = 0;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk_i);
         @(negedge clk_i);
         n_stall  += int'(dut.HazardDetection.Stall_o);
         n_flush  += int'(dut.HazardDetection.Flush_o);
         n_branch += int'(dut.Control.Branch_o);
      end
   endtask

   initial begin
      // Reset/start with all-zero instruction memory
      for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = 8'(i + 8'h40);
      prog = {};
      load_and_reset();
      check("pc_after_reset", dut.PC.pc_o, 32'd0);
      run(1); check("pc_1", dut.PC.pc_o, 32'd4);
      run(1); check("pc_2", dut.PC.pc_o, 32'd8);
      run(1); check("pc_3", dut.PC.pc_o, 32'd12);
      start_i = 1'b0;
      run(2); check("pc_hold", dut.PC.pc_o, 32'd12);
      start_i = 1'b1;
      run(6);
      acc = '0;
      for (int i = 0; i < 32; i++) acc |= dut.Registers.register[i];
      check("nop_regs_quiet", acc, 32'd0);
      acc = '0;
      for (int i = 0; i < 32; i++) if (dut.Data_Memory.memory[i] !== 8'(i + 8'h40)) acc++;
      check("nop_dmem_quiet", acc, 32'd0);

      // ALU chain, all dependencies through forwarding
      prog = {addi(1, 0, 12'd5), addi(2, 0, 12'd3),
              r_type(7'b0000000, 3'b000, 3, 1, 2), r_type(7'b0100000, 3'b000, 4, 1, 2),
              r_type(7'b0000001, 3'b000, 5, 1, 2), r_type(7'b0000000, 3'b111, 6, 1, 2),
              r_type(7'b0000000, 3'b110, 7, 1, 2)};
      load_and_reset();
      run(14);
      check("alu_stalls", n_stall, 0);
      check("alu_x1", dut.Registers.register[1], 32'd5);
      check("alu_x2", dut.Registers.register[2], 32'd3);
      check("alu_add_x3", dut.Registers.register[3], 32'd8);
      check("alu_sub_x4", dut.Registers.register[4], 32'd2);
      check("alu_mul_x5", dut.Registers.register[5], 32'd15);
      check("alu_and_x6", dut.Registers.register[6], 32'd1);
      check("alu_or_x7", dut.Registers.register[7], 32'd7);

      // Load-use stall
      dut.Data_Memory.memory[0] = 8'd5; dut.Data_Memory.memory[1] = 8'd0;
      dut.Data_Memory.memory[2] = 8'd0; dut.Data_Memory.memory[3] = 8'd0;
      prog = {lw(1, 0, 12'd0), r_type(7'b0000000, 3'b000, 2, 1, 1)};
      load_and_reset();
      run(12);
      check("lu_stalls", n_stall, 1);
      check("lu_x1", dut.Registers.register[1], 32'd5);
      check("lu_x2", dut.Registers.register[2], 32'd10);

      // Store then load back
      for (int i = 8; i < 12; i++) dut.Data_Memory.memory[i] = 8'h00;
      dut.Data_Memory.memory[12] = 8'h5A;
      prog = {addi(1, 0, 12'hFFF), sw(1, 0, 12'd8), lw(2, 0, 12'd8)};
      load_and_reset();
      run(12);
      check("st_bytes_8_11", dword(8), 32'hFFFF_FFFF);
      check("st_byte12_kept", {24'd0, dut.Data_Memory.memory[12]}, 32'h5A);
      check("st_lw_x2", dut.Registers.register[2], 32'hFFFF_FFFF);

      // Taken branch
      prog = {beq(0, 0, 13'd8), addi(1, 0, 12'd1), addi(2, 0, 12'd2)};
      load_and_reset();
      run(12);
      check("bt_flushes", n_flush, 1);
      check("bt_x1_skipped", dut.Registers.register[1], 32'd0);
      check("bt_x2_target", dut.Registers.register[2], 32'd2);

      // Not-taken branch (x1 written back just as beq reads it)
      prog = {addi(1, 0, 12'd1), 32'd0, 32'd0, beq(0, 1, 13'd8), addi(2, 0, 12'd2), addi(3, 0, 12'd3)};
      load_and_reset();
      run(14);
      check("bn_flushes", n_flush, 0);
      check("bn_branch_cycles", n_branch, 1);
      check("bn_x2", dut.Registers.register[2], 32'd2);
      check("bn_x3", dut.Registers.register[3], 32'd3);

      // Async reset while writes are in flight
      for (int i = 16; i < 20; i++) dut.Data_Memory.memory[i] = 8'h00;
      prog = {addi(1, 0, 12'd7), addi(2, 0, 12'd9), sw(1, 0, 12'd16)};
      load_and_reset();
      run(4);
      check("ar_pc_before", dut.PC.pc_o, 32'd16);
      rst_i = 1'b1;
      #1;
      check("ar_pc_async", dut.PC.pc_o, 32'd0);
      for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = '0;
      run(2);
      rst_i = 1'b0;
      run(10);
      check("ar_x1", dut.Registers.register[1], 32'd0);
      check("ar_x2", dut.Registers.register[2], 32'd0);
      check("ar_dmem16", dword(16), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
